// File: rtl/mem_mover_pkg.sv
// Shared encodings for the memory-move initiator: command opcodes and FSM states.
package mem_mover_pkg;

    localparam logic [1:0] OP_COPY_ROM = 2'd0;
    localparam logic [1:0] OP_COPY_RAM = 2'd1;
    localparam logic [1:0] OP_FILL     = 2'd2;
    localparam logic [1:0] OP_NOP      = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_XFER = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mem_mover_if.sv
// Command handshake plus ROM/RAM initiator bus of the memory mover.
interface mem_mover_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] pattern;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_store;
    logic [DW-1:0] ram_dout;

    modport master (
        input  start, op, src, dst, len, pattern, rom_data, ram_dout,
        output busy, done, rom_addr, ram_addr, ram_din, ram_store
    );

    modport slave (
        output start, op, src, dst, len, pattern, rom_data, ram_dout,
        input  busy, done, rom_addr, ram_addr, ram_din, ram_store
    );
endinterface

// File: rtl/mem_mover.sv
// Block copy ROM->RAM, RAM->RAM and RAM fill driven by a start/busy/done handshake.
// Latency: len+1 cycles (ROM copy/fill), 2*len+1 (RAM copy), 1 for len=0 or no-op.
// No backpressure: memories are combinational-read, one store per beat; start ignored while busy.
module mem_mover
    import mem_mover_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_mover_if.master bus
);

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [DW-1:0] pattern;
    } cmd_t;

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    logic [2:0]    state;
    cmd_t          cmd;
    logic [AW:0]   k;
    logic [DW-1:0] hold;
    logic          last;
    logic [AW-1:0] src_k;
    logic [AW-1:0] dst_k;

    assign last = (k == cmd.len - LEN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cmd   <= '0;
            k     <= '0;
            hold  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cmd <= '{op: bus.op, src: bus.src, dst: bus.dst,
                                 len: bus.len, pattern: bus.pattern};
                        k   <= '0;
                        if (bus.len == '0 || bus.op == OP_NOP)
                            state <= S_DONE;
                        else if (bus.op == OP_COPY_RAM)
                            state <= S_RD;
                        else
                            state <= S_XFER;
                    end
                end
                S_XFER: begin
                    k <= k + LEN_ONE;
                    if (last) state <= S_DONE;
                end
                S_RD: begin
                    hold  <= bus.ram_dout;
                    state <= S_WR;
                end
                S_WR: begin
                    k     <= k + LEN_ONE;
                    state <= last ? S_DONE : S_RD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address adders truncate to AW bits, so ranges wrap at the top of memory.
    always_comb begin
        src_k         = cmd.src + k[AW-1:0];
        dst_k         = cmd.dst + k[AW-1:0];
        bus.rom_addr  = '0;
        bus.ram_addr  = '0;
        bus.ram_din   = '0;
        bus.ram_store = 1'b0;
        case (state)
            S_XFER: begin
                bus.ram_addr  = dst_k;
                bus.ram_store = 1'b1;
                if (cmd.op == OP_COPY_ROM) begin
                    bus.rom_addr = src_k;
                    bus.ram_din  = bus.rom_data;
                end else begin
                    bus.ram_din  = cmd.pattern;
                end
            end
            S_RD: begin
                bus.ram_addr = src_k;
            end
            S_WR: begin
                bus.ram_addr  = dst_k;
                bus.ram_din   = hold;
                bus.ram_store = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_mem_mover.sv
// Directed bench for mem_mover: ROM/RAM models, store scoreboard, cycle-exact handshake checks.
module tb_mem_mover;
    import mem_mover_pkg::*;

    logic clk;
    logic rst;
    logic tb_init;

    mem_mover_if #(.AW(10), .DW(32)) bus ();
    mem_mover #(.AW(10), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
    wr_t         sb[$];
    wr_t         mon_w;
    logic [31:0] rom [1024];
    logic [31:0] ram [1024];
    logic [31:0] mdl [1024];
    int          vectors;
    int          miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.ram_dout = ram[bus.ram_addr];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.ram_store) begin
            ram[bus.ram_addr] <= bus.ram_din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every store the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.ram_store) begin
            chk("store_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                mon_w = sb.pop_front();
                chk("store_addr", 64'(bus.ram_addr), 64'(mon_w.a));
                chk("store_data", 64'(bus.ram_din), 64'(mon_w.d));
            end
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_busy0"},     64'(bus.busy),      64'(0));
        chk({nm, "_done0"},     64'(bus.done),      64'(0));
        chk({nm, "_store0"},    64'(bus.ram_store), 64'(0));
        chk({nm, "_ram_addr0"}, 64'(bus.ram_addr),  64'(0));
        chk({nm, "_ram_din0"},  64'(bus.ram_din),   64'(0));
        chk({nm, "_rom_addr0"}, 64'(bus.rom_addr),  64'(0));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_cmd(input string nm, input logic [1:0] o, input logic [9:0] s,
                           input logic [9:0] d, input logic [10:0] n, input logic [31:0] p,
                           input bit ign, input int cut);
        int          dc;
        int          nw;
        bit          reset_hit;
        logic [9:0]  wa;
        logic [31:0] wd;
        reset_hit = 1'b0;
        nw = (o == OP_NOP) ? 0 : int'(n);
        if (cut >= 0) nw = cut;
        for (int i = 0; i < nw; i++) begin
            wa = d + 10'(i);
            case (o)
                OP_COPY_ROM: wd = rom[s + 10'(i)];
                OP_COPY_RAM: wd = mdl[s + 10'(i)];
                default:     wd = p;
            endcase
            mdl[wa] = wd;
            sb.push_back({wa, wd});
        end
        if (o == OP_NOP || n == 11'd0) dc = 1;
        else if (o == OP_COPY_RAM)     dc = 2 * int'(n) + 1;
        else                           dc = int'(n) + 1;

        bus.start = 1'b1; bus.op = o; bus.src = s; bus.dst = d; bus.len = n; bus.pattern = p;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= dc; c++) begin
            if (cut >= 0 && c == cut + 1) begin
                @(posedge clk);
                #1 rst = 1'b1;
                #1 chk_idle({nm, "_rst"});
                reset_hit = 1'b1;
                break;
            end
            @(negedge clk);
            chk({nm, "_busy"},  64'(bus.busy),      64'(1));
            chk({nm, "_done"},  64'(bus.done),      64'(c == dc));
            chk({nm, "_store"}, 64'(bus.ram_store),
                64'((c != dc) && (o != OP_COPY_RAM || (c % 2) == 0)));
            if (ign && c == 3) begin
                bus.start = 1'b1; bus.op = OP_COPY_RAM; bus.src = 10'd7;
                bus.dst = 10'd900; bus.len = 11'd5; bus.pattern = 32'h0;
            end
            if (ign && c == 4) bus.start = 1'b0;
        end
        @(negedge clk);
        if (reset_hit) rst = 1'b0;
        else           chk_idle({nm, "_idle"});
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; tb_init = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.pattern = '0;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'h1000 + 32'(i);
            mdl[i] = 32'hA500_0000 | 32'(i);
        end
        @(posedge clk);
        #1 tb_init = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        run_cmd("copy_rom", OP_COPY_ROM, 10'd4, 10'd100, 11'd8, 32'h0, 1'b0, -1);
        for (int i = 0; i < 8; i++) chk("copy_rom_word", 64'(ram[100 + i]), 64'(32'h1004 + i));
        chk("copy_rom_after", 64'(ram[108]), 64'(32'hA500_006C));

        run_cmd("fill_wrap", OP_FILL, 10'd0, 10'd1020, 11'd8, 32'hDEAD_BEEF, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            chk("fill_top", 64'(ram[1020 + i]), 64'(32'hDEAD_BEEF));
            chk("fill_low", 64'(ram[i]),        64'(32'hDEAD_BEEF));
        end
        chk("fill_after", 64'(ram[4]), 64'(32'hA500_0004));

        for (int i = 0; i < 4; i++)
            run_cmd("fill_one", OP_FILL, 10'd0, 10'(i), 11'd1, 32'(i + 1), 1'b0, -1);
        run_cmd("copy_ram", OP_COPY_RAM, 10'd0, 10'd10, 11'd4, 32'h0, 1'b0, -1);
        for (int i = 0; i < 4; i++) chk("copy_ram_word", 64'(ram[10 + i]), 64'(i + 1));

        run_cmd("len0", OP_FILL, 10'd0, 10'd200, 11'd0, 32'h1234_5678, 1'b0, -1);
        run_cmd("nop",  OP_NOP,  10'd0, 10'd200, 11'd5, 32'h1234_5678, 1'b0, -1);
        chk("len0_nop_untouched", 64'(ram[200]), 64'(32'hA500_00C8));

        run_cmd("overlap", OP_COPY_RAM, 10'd10, 10'd12, 11'd4, 32'h0, 1'b0, -1);
        chk("overlap_12", 64'(ram[12]), 64'(1));
        chk("overlap_13", 64'(ram[13]), 64'(2));
        chk("overlap_14", 64'(ram[14]), 64'(1));
        chk("overlap_15", 64'(ram[15]), 64'(2));

        run_cmd("fill_rst", OP_FILL, 10'd0, 10'd0, 11'd16, 32'h5A5A_0000, 1'b0, 6);
        for (int i = 0; i < 6; i++)  chk("rst_written", 64'(ram[i]), 64'(32'h5A5A_0000));
        for (int i = 6; i < 16; i++) chk("rst_kept",    64'(ram[i]), 64'(mdl[i]));

        run_cmd("rom_wrap", OP_COPY_ROM, 10'd1022, 10'd500, 11'd4, 32'h0, 1'b0, -1);
        chk("rom_wrap_0", 64'(ram[500]), 64'(32'h13FE));
        chk("rom_wrap_1", 64'(ram[501]), 64'(32'h13FF));
        chk("rom_wrap_2", 64'(ram[502]), 64'(32'h1000));
        chk("rom_wrap_3", 64'(ram[503]), 64'(32'h1001));

        run_cmd("fill_all", OP_FILL, 10'd0, 10'd5, 11'd1024, 32'h0F0F_0F0F, 1'b0, -1);
        chk("fill_all_4",    64'(ram[4]),    64'(32'h0F0F_0F0F));
        chk("fill_all_1023", 64'(ram[1023]), 64'(32'h0F0F_0F0F));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
